// File: rtl/checkout_calc.sv
// checkout_calc: till checkout calculator with debounced coin keys, IR/voice item entry and BCD 7-segment displays
module checkout_calc #(
    parameter int                 DIGITS   = 2,
    parameter int                 NKEYS    = 3,
    parameter logic [NKEYS*8-1:0] COIN_VAL = {8'd1, 8'd2, 8'd5},
    parameter logic [31:0]        PRICE    = {8'd10, 8'd8, 8'd5, 8'd3},
    parameter int                 DEBOUNCE = 64
) (
    input  logic                  clock,
    input  logic                  clr_n,
    input  logic [NKEYS-1:0]      key,
    input  logic                  ir_valid,
    input  logic [7:0]            ir_code,
    input  logic [2:0]            voice,
    output logic [7*DIGITS-1:0]   seg_chg,
    output logic [7*DIGITS-1:0]   seg_item,
    output logic [7*DIGITS-1:0]   seg_pay,
    output logic                  item_ovf,
    output logic                  pay_ovf,
    output logic                  short,
    output logic                  busy
);
    localparam int MAX = 10**DIGITS - 1;
    localparam int VW  = $clog2(MAX + 1);
    localparam int SW  = VW + 9;
    localparam int CW  = $clog2(VW + 1);
    localparam int DW  = $clog2(DEBOUNCE + 1);
    localparam int BW  = 4 * DIGITS;
    localparam logic [6:0] SEG_F = 7'b000_1110;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

    logic [NKEYS-1:0] s1_q, s2_q, s3_q, lvl_q, lvl_d, press_q, press_d, fell, pmask;
    logic [DW-1:0]    cnt_q [NKEYS];
    logic [DW-1:0]    cnt_d [NKEYS];
    logic [2:0]       v1_q, v2_q, v3_q;
    logic [1:0]       v_item_q, v_item_d, v_code, iidx;
    logic             v_pend_q, v_pend_d, v_ok, v_new;
    logic             do_clr, do_iri, do_v, do_p, iadd, upd, restart;
    logic [7:0]       coin;
    logic [SW-1:0]    isum, psum;
    logic [VW-1:0]    item_q, item_d, pay_q, pay_d, chg;
    logic             item_ovf_q, item_ovf_d, pay_ovf_q, pay_ovf_d;
    state_t           st_q;
    logic [1:0]       sel_q;
    logic [CW-1:0]    bits_q;
    logic [VW-1:0]    bin_q;
    logic [BW-1:0]    bcd_q, bpay_q, bitem_q;
    logic             busy_q, dirty_q;
    logic [7*DIGITS-1:0] seg_chg_q, seg_item_q, seg_pay_q;

    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        for (int d = 0; d < DIGITS; d++)
            r[4*d +: 4] = b[4*d +: 4] >= 4'd5 ? b[4*d +: 4] + 4'd3 : b[4*d +: 4];
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] decode(input logic [BW-1:0] b);
        logic [7*DIGITS-1:0] r;
        for (int d = 0; d < DIGITS; d++)
            r[7*d +: 7] = SEG[b[4*d +: 4]];
        return r;
    endfunction

    assign short    = pay_q < item_q;
    assign chg      = short ? '0 : pay_q - item_q;
    assign fell     = lvl_q & ~lvl_d;
    assign item_ovf = item_ovf_q;
    assign pay_ovf  = pay_ovf_q;
    assign busy     = busy_q;
    assign seg_chg  = seg_chg_q;
    assign seg_item = seg_item_q;
    assign seg_pay  = seg_pay_q;
    assign restart  = dirty_q && (st_q == IDLE || (st_q == STORE && sel_q == 2'd2));

    // per-key debounce: any change reloads the counter, the level is accepted when it reaches 1
    always_comb begin
        for (int i = 0; i < NKEYS; i++) begin
            cnt_d[i] = s2_q[i] != s3_q[i] ? DW'(DEBOUNCE) : cnt_q[i] != '0 ? cnt_q[i] - DW'(1) : cnt_q[i];
            lvl_d[i] = s2_q[i] == s3_q[i] && cnt_q[i] == DW'(1) ? s2_q[i] : lvl_q[i];
        end
    end

    // one event per cycle: clear, IR item, voice item, lowest pending coin key
    always_comb begin
        v_code   = v2_q == 3'b100 ? 2'd0 : v2_q == 3'b010 ? 2'd1 : v2_q == 3'b110 ? 2'd2 : 2'd3;
        v_ok     = v2_q inside {3'b100, 3'b010, 3'b110, 3'b001};
        v_new    = v_ok && v2_q != v3_q;
        do_clr   = ir_valid && ir_code == 8'hFF;
        do_iri   = ir_valid && ir_code >= 8'd1 && ir_code <= 8'd4;
        do_v     = !do_clr && !do_iri && v_pend_q;
        do_p     = !do_clr && !do_iri && !v_pend_q && |press_q;
        iadd     = do_iri || do_v;
        upd      = do_clr || iadd || do_p;
        coin     = '0;
        pmask    = '0;
        for (int i = NKEYS - 1; i >= 0; i--)
            if (press_q[i]) begin
                coin  = COIN_VAL[8*i +: 8];
                pmask = NKEYS'(1) << i;
            end
        iidx       = do_iri ? 2'(ir_code - 8'd1) : v_item_q;
        isum       = SW'(item_q) + SW'(PRICE[{iidx, 3'b000} +: 8]);
        psum       = SW'(pay_q) + SW'(coin);
        item_d     = do_clr ? '0 : !iadd ? item_q : isum > SW'(MAX) ? VW'(MAX) : isum[VW-1:0];
        pay_d      = do_clr ? '0 : !do_p ? pay_q : psum > SW'(MAX) ? VW'(MAX) : psum[VW-1:0];
        item_ovf_d = !do_clr && (item_ovf_q || (iadd && isum > SW'(MAX)));
        pay_ovf_d  = !do_clr && (pay_ovf_q || (do_p && psum > SW'(MAX)));
        v_pend_d   = !do_clr && (v_new || (v_pend_q && !do_v));
        v_item_d   = v_new ? v_code : v_item_q;
        press_d    = do_clr ? '0 : (press_q & ~(do_p ? pmask : '0)) | fell;
    end

    // input synchronisers, debounce state, pending events and running totals
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            s1_q       <= '1;
            s2_q       <= '1;
            s3_q       <= '1;
            lvl_q      <= '1;
            cnt_q      <= '{default: '0};
            press_q    <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            v3_q       <= '0;
            v_pend_q   <= 1'b0;
            v_item_q   <= '0;
            item_q     <= '0;
            pay_q      <= '0;
            item_ovf_q <= 1'b0;
            pay_ovf_q  <= 1'b0;
        end else begin
            s1_q       <= key;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            lvl_q      <= lvl_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
            v1_q       <= voice;
            v2_q       <= v1_q;
            v3_q       <= v2_q;
            v_pend_q   <= v_pend_d;
            v_item_q   <= v_item_d;
            item_q     <= item_d;
            pay_q      <= pay_d;
            item_ovf_q <= item_ovf_d;
            pay_ovf_q  <= pay_ovf_d;
        end
    end

    // shared double-dabble converter: pay, item, change in turn, then all displays on one edge
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            st_q       <= IDLE;
            sel_q      <= '0;
            bits_q     <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bpay_q     <= '0;
            bitem_q    <= '0;
            busy_q     <= 1'b0;
            dirty_q    <= 1'b0;
            seg_chg_q  <= {DIGITS{SEG[0]}};
            seg_item_q <= {DIGITS{SEG[0]}};
            seg_pay_q  <= {DIGITS{SEG[0]}};
        end else begin
            dirty_q <= upd || (dirty_q && !restart);
            case (st_q)
                IDLE: begin
                    st_q   <= dirty_q ? LOAD : IDLE;
                    sel_q  <= '0;
                    busy_q <= dirty_q;
                end
                LOAD: begin
                    bin_q  <= sel_q == 2'd0 ? pay_q : sel_q == 2'd1 ? item_q : chg;
                    bcd_q  <= '0;
                    bits_q <= CW'(VW);
                    st_q   <= SHIFT;
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {dabble(bcd_q), bin_q} << 1;
                    bits_q         <= bits_q - CW'(1);
                    st_q           <= bits_q == CW'(1) ? STORE : SHIFT;
                end
                STORE: begin
                    bpay_q  <= sel_q == 2'd0 ? bcd_q : bpay_q;
                    bitem_q <= sel_q == 2'd1 ? bcd_q : bitem_q;
                    if (sel_q == 2'd2) begin
                        seg_pay_q  <= pay_ovf_q ? {DIGITS{SEG_F}} : decode(bpay_q);
                        seg_item_q <= item_ovf_q ? {DIGITS{SEG_F}} : decode(bitem_q);
                        seg_chg_q  <= short ? {DIGITS{SEG_F}} : decode(bcd_q);
                        st_q       <= dirty_q ? LOAD : IDLE;
                        busy_q     <= dirty_q;
                        sel_q      <= '0;
                    end else begin
                        sel_q <= sel_q + 2'd1;
                        st_q  <= LOAD;
                    end
                end
            endcase
        end
    end
endmodule
